lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning: max cycles spent in REQ or WAIT before abort; 0 disables the timeout.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  request pulse from core; accepted only when busy=0.
REQ-005 is_store  in  1  1=store, 0=load; sampled with start.
REQ-006 func3  in  3  load/store width code (000 B, 001 H, 010 W, 100 BU, 101 HU); sampled with start.
REQ-007 addr  in  32  byte address; sampled with start.
REQ-008 wdata  in  32  store data; sampled with start.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 fault  out  1  valid with done; 1=misaligned, illegal func3 or timeout.
REQ-012 rdata  out  32  extended load result; valid with done, held until next done.
REQ-013 mem_req  out  1  bus request.
REQ-014 mem_we  out  1  bus write enable.
REQ-015 mem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-016 mem_be  out  4  byte enables.
REQ-017 mem_wdata  out  32  lane-replicated store data.
REQ-018 mem_gnt  in  1  bus accepts request this cycle.
REQ-019 mem_rvalid  in  1  read data valid this cycle.
REQ-020 mem_rdata  in  32  read data word.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT, RESP.
REQ-022 IDLE + start: legal -> REQ; illegal/misaligned -> RESP with fault=1 and no mem_req.
REQ-023 Illegal: func3 011/110/111; store with func3 100/101. Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
REQ-024 REQ: mem_req=1 with mem_we/mem_addr/mem_be/mem_wdata stable; on mem_gnt, store -> RESP, load -> WAIT.
REQ-025 WAIT: mem_req=0; on mem_rvalid -> RESP and capture extended data into rdata; mem_rvalid in any other state is ignored.
REQ-026 RESP: done=1 for exactly one cycle -> IDLE; start in RESP is ignored.
REQ-027 mem_be: B/BU = 4'b0001<<addr[1:0]; H/HU = addr[1] ? 4'b1100 : 4'b0011; W = 4'b1111.
REQ-028 mem_wdata: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
REQ-029 Load extraction: select byte/half lane by captured addr[1:0]; sign-extend for 000/001, zero-extend for 100/101.
REQ-030 Timeout: cycle counter cleared on entry to REQ, counts in REQ and WAIT; reaching TIMEOUT -> RESP with fault=1, mem_req dropped, rdata unchanged.
REQ-031 Latency: start at cycle 0 -> mem_req at cycle 1; gnt at cycle 1 -> store done at cycle 2; load with rvalid at cycle k -> done at cycle k+1.
REQ-032 Faulted requests SHALL leave rdata unchanged.
REQ-033 Simultaneous mem_gnt and timeout expiry: gnt wins.

Reset
REQ-034 rst=1 SHALL immediately force state IDLE, counter 0, and busy, done, fault, mem_req, mem_we = 0.
REQ-035 rst=1 SHALL immediately force rdata, mem_addr, mem_be, mem_wdata = 0.
REQ-036 Reset during REQ/WAIT SHALL drop mem_req that cycle; a later mem_rvalid is ignored.

Verification
REQ-037 LW addr=0x100, gnt at cycle 1, rvalid at cycle 3 with rdata=0xDEADBEEF -> mem_be=1111, done at cycle 4, rdata=0xDEADBEEF, fault=0.
REQ-038 LB addr=0x103, mem_rdata=0x80000000 -> rdata=0xFFFFFF80; LBU with the same stimulus -> rdata=0x00000080.
REQ-039 SH addr=0x102, wdata=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, done at cycle after gnt.
REQ-040 LW addr=0x101 -> no mem_req, done with fault=1 at cycle 1; SB with func3=100 -> fault=1.
REQ-041 LW with gnt but no rvalid, TIMEOUT=16 -> done with fault=1 on the 17th cycle after entering REQ, rdata unchanged.
REQ-042 rst asserted in WAIT, rvalid pulsed next cycle -> outputs 0, no done, start then accepted normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: decodes a single core request, drives one bus
// transaction and returns an extended load result or a fault indication.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        is_store_i,
  input  logic [2:0]  func3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fault_o,
  output logic [31:0] rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic          store_q, store_d;
  logic [2:0]    func3_q, func3_d;
  logic [1:0]    offs_q, offs_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   memAddr_q, memAddr_d;
  logic [3:0]    memBe_q, memBe_d;
  logic [31:0]   memWdata_q, memWdata_d;

  logic          badReq;
  logic [3:0]    beCalc;
  logic [31:0]   wdCalc;
  logic [31:0]   laneWord;
  logic [31:0]   loadExt;
  logic          timeoutHit;

  // Decode of the incoming request: legality, alignment and lane placement.
  always_comb begin
    badReq = 1'b0;
    beCalc = 4'b1111;
    wdCalc = wdata_i;
    if (func3_i == 3'b011 || func3_i == 3'b110 || func3_i == 3'b111) badReq = 1'b1;
    if (is_store_i && func3_i[2]) badReq = 1'b1;
    case (func3_i[1:0])
      2'b00: begin
        beCalc = 4'b0001 << addr_i[1:0];
        wdCalc = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        beCalc = addr_i[1] ? 4'b1100 : 4'b0011;
        wdCalc = {2{wdata_i[15:0]}};
        if (addr_i[0]) badReq = 1'b1;
      end
      default: begin
        if (addr_i[1:0] != 2'b00) badReq = 1'b1;
      end
    endcase
  end

  assign laneWord = mem_rdata_i >> {offs_q, 3'b000};

  always_comb begin
    case (func3_q[1:0])
      2'b00:   loadExt = {{24{~func3_q[2] & laneWord[7]}}, laneWord[7:0]};
      2'b01:   loadExt = {{16{~func3_q[2] & laneWord[15]}}, laneWord[15:0]};
      default: loadExt = mem_rdata_i;
    endcase
  end

  assign timeoutHit = (TIMEOUT != 0) && (cnt_q >= TLIM);

  // Next-state logic; bus acceptance takes priority over timeout expiry.
  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    func3_d    = func3_q;
    offs_d     = offs_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    memAddr_d  = memAddr_q;
    memBe_d    = memBe_q;
    memWdata_d = memWdata_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          store_d = is_store_i;
          func3_d = func3_i;
          offs_d  = addr_i[1:0];
          if (badReq) begin
            fault_d = 1'b1;
            state_d = RESP;
          end else begin
            fault_d    = 1'b0;
            cnt_d      = '0;
            memAddr_d  = {addr_i[31:2], 2'b00};
            memBe_d    = beCalc;
            memWdata_d = wdCalc;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_gnt_i) begin
          state_d = store_q ? RESP : WAIT;
        end else if (timeoutHit) begin
          fault_d = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rvalid_i) begin
          rdata_d = loadExt;
          state_d = RESP;
        end else if (timeoutHit) begin
          fault_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      store_q    <= 1'b0;
      func3_q    <= 3'b000;
      offs_q     <= 2'b00;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      memAddr_q  <= '0;
      memBe_q    <= '0;
      memWdata_q <= '0;
    end else begin
      state_q    <= state_d;
      store_q    <= store_d;
      func3_q    <= func3_d;
      offs_q     <= offs_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      memAddr_q  <= memAddr_d;
      memBe_q    <= memBe_d;
      memWdata_q <= memWdata_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == RESP);
  assign fault_o     = done_o & fault_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = mem_req_o & store_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_be_o    = memBe_q;
  assign mem_wdata_o = memWdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: transaction-level reference model with a
// per-cycle compare process plus hand-computed literal checks.
module tb_lsu_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, isStore;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic        busy, done, fault;
  logic [31:0] rdata;
  logic        memReq, memWe;
  logic [31:0] memAddr;
  logic [3:0]  memBe;
  logic [31:0] memWdata;
  logic        memGnt, memRvalid;
  logic [31:0] memRdata;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .start_i(start), .is_store_i(isStore), .func3_i(func3),
    .addr_i(addr), .wdata_i(wdata),
    .busy_o(busy), .done_o(done), .fault_o(fault), .rdata_o(rdata),
    .mem_req_o(memReq), .mem_we_o(memWe), .mem_addr_o(memAddr),
    .mem_be_o(memBe), .mem_wdata_o(memWdata),
    .mem_gnt_i(memGnt), .mem_rvalid_i(memRvalid), .mem_rdata_i(memRdata)
  );

  int assertCount = 0;
  int failCount   = 0;

  logic        checkEn = 1'b0;
  logic        expBusy, expDone, expFault, expReq, expWe;
  logic [31:0] expAddr, expWdata, expRdata;
  logic [3:0]  expBe;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: access size, legality, lane placement and extension.
  function automatic int sizeOf(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit isBad(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (st && f3 >= 3'd4) return 1'b1;
    if ((int'(a[1:0]) % sizeOf(f3)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    logic [3:0] m;
    sz = sizeOf(f3);
    m  = 4'((1 << sz) - 1);
    return m << a[1:0];
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    int sz;
    sz = sizeOf(f3);
    r  = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rw);
    longint v;
    int sz, sh;
    sz = sizeOf(f3);
    sh = 8 * int'(a[1:0]);
    v  = longint'(rw >> sh) & ((longint'(1) << (8*sz)) - 1);
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8*sz));
    return v[31:0];
  endfunction

  // Per-cycle comparison of the DUT against the expectations of this cycle.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy", {31'b0, busy}, {31'b0, expBusy});
      checkOutput("done", {31'b0, done}, {31'b0, expDone});
      checkOutput("mem_req", {31'b0, memReq}, {31'b0, expReq});
      checkOutput("mem_we", {31'b0, memWe}, {31'b0, expWe});
      checkOutput("rdata", rdata, expRdata);
      if (expDone) checkOutput("fault", {31'b0, fault}, {31'b0, expFault});
      else         checkOutput("fault_idle", {31'b0, fault}, 32'd0);
      if (expReq) begin
        checkOutput("mem_addr", memAddr, expAddr);
        checkOutput("mem_be", {28'b0, memBe}, {28'b0, expBe});
        checkOutput("mem_wdata", memWdata, expWdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    expBusy = 1'b0; expDone = 1'b0; expFault = 1'b0; expReq = 1'b0; expWe = 1'b0;
  endtask

  // One complete transaction. gntAt/rvAt: cycles spent in REQ/WAIT before the
  // bus responds (-1 = never).
  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input int gntAt, input int rvAt,
                               input logic [31:0] rw);
    bit bad, inReq, finished, flt, ev;
    int n, k;
    bad = isBad(st, f3, a);
    start = 1'b1; isStore = st; func3 = f3; addr = a; wdata = wd;
    setIdle();
    tick();
    start = 1'b0; isStore = ~st; func3 = 3'b111; addr = ~a; wdata = ~wd;
    flt = bad;
    if (!bad) begin
      n = 0; k = 0; inReq = 1'b1; finished = 1'b0;
      while (!finished) begin
        expBusy = 1'b1; expDone = 1'b0; expReq = inReq; expWe = inReq & st;
        expAddr = {a[31:2], 2'b00}; expBe = modelBe(f3, a); expWdata = modelWdata(f3, wd);
        ev = inReq ? (k == gntAt) : (k == rvAt);
        memGnt    = inReq && ev;
        memRvalid = inReq ? 1'b1 : ev;
        memRdata  = inReq ? 32'h5A5A5A5A : rw;
        tick();
        memGnt = 1'b0; memRvalid = 1'b0;
        if (ev) begin
          if (inReq && !st) begin
            inReq = 1'b0;
            k = 0;
          end else begin
            finished = 1'b1;
            if (!inReq) expRdata = modelLoad(f3, a, rw);
          end
        end else if (n >= TO - 1) begin
          finished = 1'b1;
          flt = 1'b1;
        end else begin
          k++;
        end
        n++;
      end
    end
    expBusy = 1'b1; expDone = 1'b1; expFault = flt; expReq = 1'b0; expWe = 1'b0;
    start = 1'b1; isStore = 1'b0; func3 = 3'b010; addr = 32'h0; wdata = 32'h0;
    tick();
    start = 1'b0;
    setIdle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; isStore = 1'b0; func3 = 3'b0; addr = '0; wdata = '0;
    memGnt = 1'b0; memRvalid = 1'b0; memRdata = '0;
    expRdata = '0; expAddr = '0; expWdata = '0; expBe = '0;
    setIdle();
    #3;
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_req", {31'b0, memReq}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_be", {28'b0, memBe}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkEn = 1'b1;

    checkOutput("model_LB", modelLoad(3'b000, 32'h103, 32'h80000000), 32'hFFFFFF80);
    checkOutput("model_LBU", modelLoad(3'b100, 32'h103, 32'h80000000), 32'h00000080);
    checkOutput("model_SH_be", {28'b0, modelBe(3'b001, 32'h102)}, 32'h0000000C);
    checkOutput("model_SH_wd", modelWdata(3'b001, 32'h1234ABCD), 32'hABCDABCD);

    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF);
    checkOutput("LW_rdata", rdata, 32'hDEADBEEF);
    applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 1, 0, 32'h80000000);
    checkOutput("LB_rdata", rdata, 32'hFFFFFF80);
    applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 1, 0, 32'h80000000);
    checkOutput("LBU_rdata", rdata, 32'h00000080);
    applyStimulus(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 0, -1, 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h11111111);
    checkOutput("LW_mis_rdata", rdata, 32'h00000080);
    applyStimulus(1'b1, 3'b100, 32'h100, 32'hFF, 0, -1, 32'h0);
    applyStimulus(1'b0, 3'b001, 32'h106, 32'h0, 0, 2, 32'h80017FFF);
    checkOutput("LH_rdata", rdata, 32'hFFFF8001);
    applyStimulus(1'b0, 3'b101, 32'h104, 32'h0, 2, 0, 32'h1234F00D);
    checkOutput("LHU_rdata", rdata, 32'h0000F00D);
    applyStimulus(1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 2, -1, 32'h0);
    applyStimulus(1'b1, 3'b000, 32'h301, 32'h000000A5, 0, -1, 32'h0);
    applyStimulus(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h22222222);
    applyStimulus(1'b0, 3'b010, 32'h500, 32'h0, 0, -1, 32'h33333333);
    checkOutput("TO_wait_rdata", rdata, 32'h0000F00D);
    applyStimulus(1'b0, 3'b010, 32'h504, 32'h0, -1, -1, 32'h44444444);
    applyStimulus(1'b0, 3'b010, 32'h508, 32'h0, TO - 1, 0, 32'h55667788);
    checkOutput("gnt_wins_rdata", rdata, 32'h55667788);

    // Reset in WAIT followed by a stray read response.
    checkEn = 1'b0;
    start = 1'b1; isStore = 1'b0; func3 = 3'b010; addr = 32'h400; wdata = '0;
    tick();
    start = 1'b0; memGnt = 1'b1;
    tick();
    memGnt = 1'b0;
    checkOutput("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("arst_busy", {31'b0, busy}, 32'd0);
    checkOutput("arst_req", {31'b0, memReq}, 32'd0);
    checkOutput("arst_rdata", rdata, 32'd0);
    checkOutput("arst_addr", memAddr, 32'd0);
    checkOutput("arst_wdata", memWdata, 32'd0);
    tick();
    rst = 1'b0; memRvalid = 1'b1; memRdata = 32'hFFFFFFFF;
    tick();
    memRvalid = 1'b0;
    checkOutput("post_rst_done", {31'b0, done}, 32'd0);
    checkOutput("post_rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("post_rst_rdata", rdata, 32'd0);
    expRdata = '0;
    setIdle();
    checkEn = 1'b1;
    applyStimulus(1'b0, 3'b010, 32'h600, 32'h0, 0, 0, 32'h11223344);
    checkOutput("after_rst_rdata", rdata, 32'h11223344);
    tick();
    checkEn = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
